// File: rtl/store_rmw_sequencer_pkg.sv
// Shared definitions for the store read-modify-write sequencer:
// store size encodings, FSM state encoding, counter width and the
// request legality check.
package store_rmw_sequencer_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Illegal size, or (when alignment is checked) misaligned sw/sh
  function automatic logic is_bad_req(input logic [1:0] size,
                                      input logic [1:0] off,
                                      input logic       check_align);
    logic misaligned;
    misaligned = ((size == SZ_WORD) && (off != 2'b00)) ||
                 ((size == SZ_HALF) && off[0]);
    return (size == 2'b11) || (check_align && misaligned);
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: inserts the store halfword/byte into the
// memory word at the little-endian lane selected by the byte offset.
// Ports:
//   size    - store size (00 word, 01 half, 10 byte)
//   off     - byte offset addr[1:0]
//   wdata   - register-B data
//   rd_word - word read from memory
//   merged  - word to write back
module store_lane_merge
  import store_rmw_sequencer_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  output logic [31:0] merged
);

  always_comb begin
    merged = rd_word;
    unique case (size)
      SZ_WORD: merged = wdata;
      SZ_HALF: begin
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      SZ_BYTE: begin
        unique case (off)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: merged = rd_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_sequencer.sv
// Multicycle store engine: sw writes directly, sh/sb read the word,
// merge the addressed lane and write it back.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start, size, addr,  - request (sampled only in IDLE)
//   wdata
//   busy, done, err     - status (done/err are one-cycle pulses)
//   mem_addr, mem_wr,   - word-aligned memory interface
//   mem_wdata, mem_rdata
module store_rmw_sequencer
  import store_rmw_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LAT     = 1,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, wdata_q, rd_q, merged;
  logic [1:0]         size_q;
  logic               err_q;
  logic               load, rd_load, bad_req;

  assign bad_req = is_bad_req(size, addr[1:0], CHECK_ALIGN);

  store_lane_merge u_merge (
    .size    (size_q),
    .off     (addr_q[1:0]),
    .wdata   (wdata_q),
    .rd_word (rd_q),
    .merged  (merged)
  );

  // State, counter and latched request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_WORD;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        size_q  <= size;
        err_q   <= bad_req;
      end
      if (rd_load) rd_q <= mem_rdata;
    end
  end

  // Next state and outputs decoded from registered state only
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    rd_load   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (bad_req) begin
            state_d = ST_DONE;
          end else if (size == SZ_WORD) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
            cnt_d   = CNT_W'(MEM_LAT - 1);
          end
        end
      end
      ST_READ: begin
        busy     = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        if (cnt_q == '0) state_d = ST_MERGE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_MERGE: begin
        busy     = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        rd_load  = 1'b1;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = merged;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Bench for store_rmw_sequencer: three instances (MEM_LAT 1/3 with
// alignment checking, MEM_LAT 2 without) share the request inputs.
module tb_store_rmw_sequencer;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy [N];
  logic        done [N];
  logic        err  [N];
  logic        mem_wr [N];
  logic [31:0] mem_addr [N];
  logic [31:0] mem_wdata [N];

  always #5 clk = ~clk;

  store_rmw_sequencer #(.MEM_LAT(1), .CHECK_ALIGN(1'b1)) u_a (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .mem_addr(mem_addr[0]),
    .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata));
  store_rmw_sequencer #(.MEM_LAT(3), .CHECK_ALIGN(1'b1)) u_b (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .mem_addr(mem_addr[1]),
    .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata));
  store_rmw_sequencer #(.MEM_LAT(2), .CHECK_ALIGN(1'b0)) u_c (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy[2]), .done(done[2]), .err(err[2]), .mem_addr(mem_addr[2]),
    .mem_wr(mem_wr[2]), .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata));

  int checks = 0;
  int errors = 0;

  // Per-instance observations of the last transaction
  int          wr_cnt [N];
  int          wr_cyc [N];
  int          done_cyc [N];
  logic [31:0] wr_addr [N];
  logic [31:0] wr_data [N];
  logic        err_seen [N];
  logic        finished;

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] mw;
    logic        e_al;   // expected err, alignment-checked instances
    logic [31:0] d_al;   // expected written word, alignment-checked
    logic        e_na;   // expected err, unchecked instance
    logic [31:0] d_na;   // expected written word, unchecked
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one request at the current negedge, then follow all
  // instances until every one has pulsed done and returned to IDLE.
  // pulse_mask bit k drives a spurious start during cycle k.
  task automatic run(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] mw, input logic [31:0] pulse_mask);
    for (int i = 0; i < N; i++) begin
      wr_cnt[i] = 0; wr_cyc[i] = -1; done_cyc[i] = -1;
      wr_addr[i] = '0; wr_data[i] = '0; err_seen[i] = 1'b0;
    end
    finished  = 1'b0;
    size      = sz; addr = a; wdata = wd; mem_rdata = mw; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k < 40; k++) begin
      logic all_idle;
      @(negedge clk);
      all_idle = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (mem_wr[i]) begin
          if (wr_cnt[i] == 0) begin
            wr_cyc[i] = k; wr_addr[i] = mem_addr[i]; wr_data[i] = mem_wdata[i];
          end
          wr_cnt[i]++;
        end
        if (err[i]) err_seen[i] = 1'b1;
        if (done[i] && done_cyc[i] < 0) done_cyc[i] = k;
        if (busy[i] || done_cyc[i] < 0) all_idle = 1'b0;
      end
      if (all_idle) begin
        finished = 1'b1;
        break;
      end
      // Latched request must not follow later input changes
      start = pulse_mask[k];
      size  = 2'b00;
      addr  = ~a;
      wdata = ~wd;
    end
    start = 1'b0;
    chk("timeout", 32'(finished), 32'd1);
  endtask

  task automatic check_vec(input string tag, input logic [1:0] sz, input logic [31:0] a,
                           input logic e_al, input logic [31:0] d_al,
                           input logic e_na, input logic [31:0] d_na);
    for (int i = 0; i < N; i++) begin
      logic        e;
      logic [31:0] d;
      int          lat;
      string       nm;
      e   = (i == 2) ? e_na : e_al;
      d   = (i == 2) ? d_na : d_al;
      lat = lat_of(i);
      nm  = $sformatf("%s/i%0d", tag, i);
      chk({nm, " err"}, 32'(err_seen[i]), 32'(e));
      chk({nm, " done_cyc"}, 32'(done_cyc[i]), e ? 32'd1 : ((sz == 2'b00) ? 32'd2 : 32'(lat + 3)));
      chk({nm, " wr_cnt"}, 32'(wr_cnt[i]), e ? 32'd0 : 32'd1);
      if (!e) begin
        chk({nm, " wr_cyc"}, 32'(wr_cyc[i]), (sz == 2'b00) ? 32'd1 : 32'(lat + 2));
        chk({nm, " wr_addr"}, wr_addr[i], {a[31:2], 2'b00});
        chk({nm, " wr_data"}, wr_data[i], d);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b00, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    tbl[1]  = '{2'b00, 32'h302, 32'hCAFEF00D, 32'h0,        1'b1, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[2]  = '{2'b10, 32'h102, 32'h000000AA, 32'h11223344, 1'b0, 32'h11AA3344, 1'b0, 32'h11AA3344};
    tbl[3]  = '{2'b01, 32'h206, 32'h0000BEEF, 32'hFFFFFFFF, 1'b0, 32'hBEEFFFFF, 1'b0, 32'hBEEFFFFF};
    tbl[4]  = '{2'b01, 32'h101, 32'h0000BEEF, 32'h11223344, 1'b1, 32'h0,        1'b0, 32'h1122BEEF};
    tbl[5]  = '{2'b11, 32'h100, 32'h12345678, 32'h0,        1'b1, 32'h0,        1'b1, 32'h0};
    tbl[6]  = '{2'b10, 32'h103, 32'h123456C3, 32'h00000000, 1'b0, 32'hC3000000, 1'b0, 32'hC3000000};
    tbl[7]  = '{2'b01, 32'h200, 32'hFFFF5A5A, 32'h89ABCDEF, 1'b0, 32'h89AB5A5A, 1'b0, 32'h89AB5A5A};
    tbl[8]  = '{2'b10, 32'h100, 32'h00000055, 32'hAABBCCDD, 1'b0, 32'hAABBCC55, 1'b0, 32'hAABBCC55};
    tbl[9]  = '{2'b10, 32'h101, 32'h00000066, 32'hAABBCCDD, 1'b0, 32'hAABB66DD, 1'b0, 32'hAABB66DD};
    tbl[10] = '{2'b01, 32'h102, 32'h00001234, 32'hAABBCCDD, 1'b0, 32'h1234CCDD, 1'b0, 32'h1234CCDD};
    tbl[11] = '{2'b00, 32'h7FC, 32'h0BADF00D, 32'h0,        1'b0, 32'h0BADF00D, 1'b0, 32'h0BADF00D};

    reset = 1'b1; start = 1'b0; size = 2'b00; addr = '0; wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst/i%0d busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst/i%0d done", i), 32'(done[i]), 32'd0);
      chk($sformatf("rst/i%0d err", i), 32'(err[i]), 32'd0);
      chk($sformatf("rst/i%0d mem_wr", i), 32'(mem_wr[i]), 32'd0);
      chk($sformatf("rst/i%0d mem_addr", i), mem_addr[i], 32'd0);
      chk($sformatf("rst/i%0d mem_wdata", i), mem_wdata[i], 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Table vectors, issued back to back
    for (int v = 0; v < NV; v++) begin
      run(tbl[v].sz, tbl[v].a, tbl[v].wd, tbl[v].mw, 32'h0);
      check_vec($sformatf("vec%0d", v), tbl[v].sz, tbl[v].a,
                tbl[v].e_al, tbl[v].d_al, tbl[v].e_na, tbl[v].d_na);
    end

    // Spurious starts while active (cycles 1..3), then an immediate second sh
    run(2'b01, 32'h206, 32'h0000BEEF, 32'hFFFFFFFF, 32'h0000000E);
    check_vec("pulse", 2'b01, 32'h206, 1'b0, 32'hBEEFFFFF, 1'b0, 32'hBEEFFFFF);
    run(2'b01, 32'h204, 32'h0000CAFE, 32'h01020304, 32'h0);
    check_vec("b2b", 2'b01, 32'h204, 1'b0, 32'h0102CAFE, 1'b0, 32'h0102CAFE);

    // Asynchronous reset in the middle of an sb read
    size = 2'b10; addr = 32'h102; wdata = 32'hAA; mem_rdata = 32'h11223344; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("midrst busy_before", 32'(busy[1]), 32'd1);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("midrst/i%0d busy", i), 32'(busy[i]), 32'd0);
      chk($sformatf("midrst/i%0d mem_wr", i), 32'(mem_wr[i]), 32'd0);
      chk($sformatf("midrst/i%0d done", i), 32'(done[i]), 32'd0);
      chk($sformatf("midrst/i%0d mem_addr", i), mem_addr[i], 32'd0);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    run(2'b00, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0);
    check_vec("postrst", 2'b00, 32'h100, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_rmw_sequencer.md
Name: store_rmw_sequencer

Overview:
- Multicycle store engine between the control unit and data memory for sw/sh/sb.
- sw writes the full word directly.
- sh/sb perform a read-modify-write: read the memory word, merge the register-B halfword/byte into the addressed lane, write the word back.
- Merging uses the same selector encoding as the store-merge path: 00 word, 01 half, 10 byte.

Parameters:
- MEM_LAT, 1: cycles from read address presented to mem_rdata valid; range 1..15.
- CHECK_ALIGN, 1: 1 flags misaligned sw/sh as error; 0 ignores the offending low address bits.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- size  in  2  00 sw, 01 sh, 10 sb, 11 illegal
- addr  in  32  byte address of the store
- wdata  in  32  register-B data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for illegal size or misaligned access
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wr  out  1  memory write enable (1 = write, 0 = read)
- mem_wdata  out  32  word to write
- mem_rdata  in  32  memory read data

Behaviour:
- Reset is asynchronous and active-high. Reset forces IDLE, counter=0 and all outputs 0 immediately, including mid-transaction; a write in progress is aborted with mem_wr dropping at once.
- Start in IDLE latches addr, wdata and size into internal registers; later changes on those inputs are ignored. Start outside IDLE is ignored.
- Lane mapping is little-endian: byte k = bits [8k+7:8k] for addr[1:0]=k. Halfword h = bits [16h+15:16h] for addr[1].
- States:
  - IDLE: busy=0, mem_wr=0. On start:
    - size=11, or misaligned with CHECK_ALIGN=1 (sw with addr[1:0]!=0, sh with addr[0]=1) -> DONE with err.
    - sw -> WRITE.
    - sh/sb -> READ.
  - READ: mem_addr driven, mem_wr=0. Stays MEM_LAT cycles using a down-counter, then -> MERGE.
  - MERGE: mem_rdata registered into rd_q; merged word computed; -> WRITE.
  - WRITE: exactly one cycle with mem_wr=1 and mem_addr/mem_wdata stable. mem_wdata is wdata (sw) or the merged word (sh/sb). -> DONE.
  - DONE: done=1 (err=1 if error path); -> IDLE. No mem_wr on the error path.
- Merge rule: sh replaces only the selected halfword with wdata[15:0]; sb replaces only the selected byte with wdata[7:0]. All other bits come from rd_q unchanged.
- Latency, start accepted at cycle 0:
  - sw: WRITE at cycle 1, done at cycle 2.
  - sh/sb: READ cycles 1..MEM_LAT, MERGE at MEM_LAT+1, WRITE at MEM_LAT+2, done at MEM_LAT+3.
  - error: done+err at cycle 1.
- Back-to-back: a new start is accepted the cycle after DONE (the cycle spent in IDLE). Minimum spacing: 3 cycles for sw, MEM_LAT+4 for sh/sb.
- Outputs are decoded from registered state and latched data only; there is no combinational path from start, size, addr or wdata to any output.

Decomposition:
- Shared package:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - state encoding (IDLE, READ, MERGE, WRITE, DONE).
- One sub-module: store_lane_merge, purely combinational (size, byte offset, wdata, rd_q -> merged word). It is instantiated inside the FSM block and reusable by the bench as a reference model.

Test Plan:
- sw, addr=0x100, wdata=0xDEADBEEF -> mem_wr=1 at cycle 1 with mem_addr=0x100, mem_wdata=0xDEADBEEF; done=1, err=0 at cycle 2; no read cycle.
- sb, addr=0x102, wdata=0x000000AA, memory word=0x11223344, MEM_LAT=1 -> READ at cycle 1, mem_wr=1 with mem_wdata=0x11AA3344 at cycle 3, done at cycle 4.
- sh, addr=0x206, wdata=0x0000BEEF, memory=0xFFFFFFFF, MEM_LAT=3 -> mem_wdata=0xBEEFFFFF at cycle 5, done at cycle 6.
- Error cases:
  - sh addr=0x101 (CHECK_ALIGN=1) -> done=1, err=1 at cycle 1, mem_wr never high.
  - size=11 -> same response.
  - sh addr=0x101 with CHECK_ALIGN=0 -> treated as addr 0x100, lower halfword written.
- Reset asserted during READ of an sb -> busy, mem_wr, done drop immediately with no clock edge. After release, a new sw completes normally with no residual write.
- Start pulsed during READ and WRITE of an active sh -> ignored, exactly one write observed. A second start in the IDLE cycle after DONE is accepted.
